ydriver_scan_array: RTL and testbench
=====================================

// Module: ydriver_scan_array
// PURPOSE
//  Parametrised LCD row (Y) driver: LANES lanes sharing one select-token shift register,
//  a frame-polarity (FR) generator and per-lane polarity-encoded outputs. Replaces per-lane
//  hand-chained shift cells with one synchronous block.
//  Adds scan direction, line-inversion FR, blanking, frame-done and restart reporting.
//  Sits between the LCD timing controller (line strobe, frame start) and the row pad drivers.
// PARAMETERS
//  LANES     144  number of row lanes driven
//  FR_LINES  0    0: FR toggles only at frame start; N>0: FR also toggles every N line steps
//  IDXW      $clog2(LANES+1)  row_idx width (derived, not overridden)
// PORTS
//  clk          in   1      system clock; all state on rising edge
//  rst_n        in   1      asynchronous active-low reset
//  line_stb     in   1      one-cycle line-step pulse; all state advances only when high
//  frame_s      in   1      frame start; sampled only when line_stb=1
//  dir          in   1      0: scan lane 0 -> LANES-1; 1: LANES-1 -> 0; latched at frame start
//  gate         in   1      select-window enable; combinational into lane_out
//  blank        in   1      forces all lanes non-selected; combinational
//  lane_out     out  LANES  drive level per lane = ~(fr_out ^ sel[i])
//  fr_out       out  1      current frame polarity
//  row_idx      out  IDXW   lane index holding token; LANES when idle
//  busy         out  1      1 while state=SCAN
//  frame_done   out  1      one-cycle pulse after token leaves last lane
//  restart_err  out  1      one-cycle pulse when frame_s arrives while SCAN
// BEHAVIOUR
//  - Reset (async, immediate, also mid-frame): tok=0, state=IDLE, dir_q=0, fr=0, line_cnt=0,
//    frame_done=0, restart_err=0, row_idx=LANES, busy=0, so lane_out = all 1s.
//  - sel[i] = tok[i] & gate & ~blank. lane_out is combinational from registered tok/fr.
//  - State IDLE: tok=0. On line_stb & frame_s -> SCAN. dir_q<=dir.
//    tok<=one-hot at lane 0 (dir=0) or lane LANES-1 (dir=1).
//  - State SCAN, line_stb & ~frame_s: token shifts one lane toward the far end.
//    dir_q decides the direction. A change on dir mid-frame is ignored.
//    If the token is at the far end: tok<=0 and state->IDLE.
//    frame_done=1 for exactly the next cycle.
//  - SCAN, line_stb & frame_s: restart. Reload tok at the start lane using the new dir.
//    Stay in SCAN and pulse restart_err.
//    If the token was at the far end on that same step, frame_done also pulses.
//  - Token is always one-hot or zero. No other value is reachable.
//  - FR: line_cnt has $clog2(FR_LINES) bits (unused when FR_LINES=0).
//    On line_stb & frame_s: fr toggles and line_cnt<=0.
//    Else on line_stb with FR_LINES>0: line_cnt increments.
//    At FR_LINES-1 it wraps to 0 and fr toggles.
//    FR runs in IDLE and SCAN alike.
//  - Latency: tok/fr/row_idx update 1 cycle after the line_stb edge. No gaps required between strobes.
//    line_stb on consecutive cycles is legal.
//  - LANES=1: frame start selects lane 0 and the next step ends the frame.
// STRUCTURE
//  - ydriver_pkg: state enum {IDLE, SCAN}, DIR_FWD/DIR_REV constants, FR mode constants.
//  - Sub-module ydriver_fr_gen: owns fr and line_cnt.
//    Inputs: clk, rst_n, line_stb, frame_s. Param FR_LINES. Output: fr.
//  - Top holds the token register, FSM, row_idx encoder (priority-free, one-hot to binary)
//    and output logic.
// TESTING (LANES=4 unless stated)
//  1. Reset, then frame_s+strobe, dir=0, gate=1. Then 4 strobes.
//     -> row_idx 0,1,2,3,4; lane_out reflects sel=0001..1000 with polarity ~(fr^sel).
//     -> frame_done pulses once after 4th strobe.
//  2. dir=1 at frame start, dir toggled mid-frame -> row_idx 3,2,1,0,4.
//     -> Mid-frame dir change has no effect.
//  3. FR_LINES=0 vs FR_LINES=2, 3 frames of 5 strobes.
//     -> fr toggles only at frame_s, vs also every 2nd strobe with line_cnt reset at frame_s.
//  4. frame_s at row_idx=2 -> restart_err pulse, row_idx=0 next. frame_s on the last-lane
//     step -> frame_done and restart_err in the same cycle.
//  5. blank=1 or gate=0 during SCAN -> lane_out = ~fr for all lanes. Token still advances.
//  6. rst_n low at row_idx=2 -> outputs at reset values immediately (before next clk).
//     Idle until next frame_s.

Source files
------------

// File: rtl/ydriver_pkg.sv
// Shared types and constants for the LCD row (Y) driver.
package ydriver_pkg;

    // FSM encodings, kept as plain constants so older tools can use them too.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    typedef enum logic [0:0] {
        IDLE = ST_IDLE,
        SCAN = ST_SCAN
    } state_e;

    // Scan direction as seen on the dir input.
    localparam logic DIR_FWD = 1'b0;   // lane 0 -> LANES-1
    localparam logic DIR_REV = 1'b1;   // lane LANES-1 -> 0

    // FR_LINES mode: zero means polarity flips only at frame start.
    localparam int FR_FRAME_ONLY = 0;

endpackage

// File: rtl/ydriver_fr_gen.sv
// Frame-polarity (FR) generator: toggles at every frame start and,
// when FR_LINES > 0, additionally every FR_LINES line steps.
module ydriver_fr_gen
    import ydriver_pkg::*;
#(
    parameter int FR_LINES = FR_FRAME_ONLY
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_stb,
    input  logic frame_s,
    output logic fr
);

    logic fr_q;

    generate
        if (FR_LINES > 0) begin : g_line_inv
            // A counter of at least one bit keeps FR_LINES == 1 legal.
            localparam int CW = (FR_LINES > 1) ? $clog2(FR_LINES) : 1;
            localparam logic [CW-1:0] LAST = CW'(FR_LINES - 1);

            logic [CW-1:0] line_cnt;

            // Line counter and polarity; frame start realigns the count.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    line_cnt <= '0;
                    fr_q     <= 1'b0;
                end else if (line_stb) begin
                    if (frame_s) begin
                        fr_q     <= ~fr_q;
                        line_cnt <= '0;
                    end else if (line_cnt == LAST) begin
                        fr_q     <= ~fr_q;
                        line_cnt <= '0;
                    end else begin
                        line_cnt <= line_cnt + 1'b1;
                    end
                end
            end
        end else begin : g_frame_only
            // Polarity flips on frame start only.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    fr_q <= 1'b0;
                end else if (line_stb && frame_s) begin
                    fr_q <= ~fr_q;
                end
            end
        end
    endgenerate

    assign fr = fr_q;

endmodule

// File: rtl/ydriver_scan_array.sv
// LCD row (Y) driver: one select token walks across LANES lanes, one lane
// per line strobe, with the output level polarity-encoded against FR.
module ydriver_scan_array
    import ydriver_pkg::*;
#(
    parameter int LANES    = 144,
    parameter int FR_LINES = FR_FRAME_ONLY,
    localparam int IDXW    = $clog2(LANES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             line_stb,
    input  logic             frame_s,
    input  logic             dir,
    input  logic             gate,
    input  logic             blank,
    output logic [LANES-1:0] lane_out,
    output logic             fr_out,
    output logic [IDXW-1:0]  row_idx,
    output logic             busy,
    output logic             frame_done,
    output logic             restart_err
);

    localparam logic [LANES-1:0] FIRST_LANE = LANES'(1'b1);
    localparam logic [LANES-1:0] LAST_LANE  = FIRST_LANE << (LANES - 1);

    state_e           state;
    logic             dir_q;
    logic [LANES-1:0] tok;
    logic             done_q;
    logic             rerr_q;
    logic             fr;
    logic             at_end;
    logic [LANES-1:0] start_tok;
    logic [LANES-1:0] sel;
    logic [IDXW-1:0]  idx;

    ydriver_fr_gen #(
        .FR_LINES (FR_LINES)
    ) u_fr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .line_stb (line_stb),
        .frame_s  (frame_s),
        .fr       (fr)
    );

    // Far end depends on the direction latched at frame start; the start
    // lane for a (re)load depends on the live dir input.
    always_comb begin
        at_end    = (dir_q == DIR_REV) ? tok[0] : tok[LANES-1];
        start_tok = (dir == DIR_REV) ? LAST_LANE : FIRST_LANE;
    end

    // Scan FSM, token shift register and the one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            dir_q  <= DIR_FWD;
            tok    <= '0;
            done_q <= 1'b0;
            rerr_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            rerr_q <= 1'b0;
            if (line_stb) begin
                case (state)
                    IDLE: begin
                        if (frame_s) begin
                            state <= SCAN;
                            dir_q <= dir;
                            tok   <= start_tok;
                        end
                    end
                    SCAN: begin
                        if (frame_s) begin
                            // Restart mid-frame; a frame ending on this same
                            // step is still reported as done.
                            dir_q  <= dir;
                            tok    <= start_tok;
                            rerr_q <= 1'b1;
                            done_q <= at_end;
                        end else if (at_end) begin
                            state  <= IDLE;
                            tok    <= '0;
                            done_q <= 1'b1;
                        end else if (dir_q == DIR_REV) begin
                            tok <= tok >> 1;
                        end else begin
                            tok <= tok << 1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        tok   <= '0;
                    end
                endcase
            end
        end
    end

    // One-hot to binary by OR-ing lane indices; LANES marks "no token".
    always_comb begin
        idx = '0;
        for (int i = 0; i < LANES; i++) begin
            if (tok[i]) begin
                idx = idx | IDXW'(i);
            end
        end
        row_idx = (tok == '0) ? IDXW'(LANES) : idx;
    end

    // Select window and polarity encoding toward the pads.
    always_comb begin
        sel      = tok & {LANES{gate & ~blank}};
        lane_out = ~({LANES{fr}} ^ sel);
    end

    assign fr_out      = fr;
    assign busy        = (state == SCAN);
    assign frame_done  = done_q;
    assign restart_err = rerr_q;

endmodule

// File: tb/tb_ydriver_scan_array.sv
// Bench for ydriver_scan_array with LANES=4: one instance with FR_LINES=0
// and one with FR_LINES=2 sharing the same stimulus.
module tb_ydriver_scan_array;

    localparam int LANES = 4;
    localparam int IDXW  = $clog2(LANES + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             line_stb = 1'b0;
    logic             frame_s = 1'b0;
    logic             dir = 1'b0;
    logic             gate = 1'b1;
    logic             blank = 1'b0;

    logic [LANES-1:0] lane_a, lane_b;
    logic             fr_a, fr_b;
    logic [IDXW-1:0]  row_a, row_b;
    logic             busy_a, busy_b;
    logic             done_a, done_b;
    logic             rerr_a, rerr_b;

    ydriver_scan_array #(.LANES(LANES), .FR_LINES(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .line_stb(line_stb), .frame_s(frame_s),
        .dir(dir), .gate(gate), .blank(blank), .lane_out(lane_a),
        .fr_out(fr_a), .row_idx(row_a), .busy(busy_a),
        .frame_done(done_a), .restart_err(rerr_a)
    );

    ydriver_scan_array #(.LANES(LANES), .FR_LINES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .line_stb(line_stb), .frame_s(frame_s),
        .dir(dir), .gate(gate), .blank(blank), .lane_out(lane_b),
        .fr_out(fr_b), .row_idx(row_b), .busy(busy_b),
        .frame_done(done_b), .restart_err(rerr_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit fs;
        bit d;
        bit g;
        bit b;
        int gap;
        int row;
        bit done;
        bit rerr;
        bit fr0;
        bit fr2;
    } vec_t;

    typedef struct {
        int row;
        bit done;
        bit rerr;
        bit fr0;
        bit fr2;
    } exp_t;

    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb[$];
    exp_t cur;
    bit   mon_en = 1'b0;
    bit   stb_seen;
    vec_t vecs[22];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input int fs, input int d, input int g, input int b,
                                input int gap, input int row, input int done,
                                input int rerr, input int fr0, input int fr2);
        vec_t v;
        v.fs = (fs != 0); v.d = (d != 0); v.g = (g != 0); v.b = (b != 0);
        v.gap = gap; v.row = row; v.done = (done != 0); v.rerr = (rerr != 0);
        v.fr0 = (fr0 != 0); v.fr2 = (fr2 != 0);
        return v;
    endfunction

    // Expected pad levels from token position, polarity and live gate/blank.
    function automatic int exp_lanes(input int row, input bit fr, input bit g, input bit b);
        int r = 0;
        for (int i = 0; i < LANES; i++) begin
            bit s = (row == i) && g && !b;
            if (!(fr ^ s)) r = r | (1 << i);
        end
        return r;
    endfunction

    // Scoreboard monitor: a strobed edge pops the next expectation, any
    // other edge keeps the previous one with the pulses cleared.
    always @(posedge clk) begin
        if (mon_en) begin
            stb_seen = line_stb;
            #1;
            if (stb_seen) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL scoreboard_underflow: got empty queue, expected entry");
                end else begin
                    cur = sb.pop_front();
                end
            end else begin
                cur.done = 1'b0;
                cur.rerr = 1'b0;
            end
            chk("row_idx", int'(row_a), cur.row);
            chk("lane_out", int'(lane_a), exp_lanes(cur.row, cur.fr0, gate, blank));
            chk("fr_out_fr0", int'(fr_a), int'(cur.fr0));
            chk("fr_out_fr2", int'(fr_b), int'(cur.fr2));
            chk("busy", int'(busy_a), int'(cur.row != LANES));
            chk("frame_done", int'(done_a), int'(cur.done));
            chk("restart_err", int'(rerr_a), int'(cur.rerr));
        end
    end

    task automatic drive_vec(input vec_t v);
        exp_t e;
        @(negedge clk);
        line_stb = 1'b1; frame_s = v.fs; dir = v.d; gate = v.g; blank = v.b;
        e.row = v.row; e.done = v.done; e.rerr = v.rerr; e.fr0 = v.fr0; e.fr2 = v.fr2;
        sb.push_back(e);
        for (int k = 0; k < v.gap; k++) begin
            @(negedge clk);
            line_stb = 1'b0; frame_s = 1'b0;
        end
    endtask

    task automatic strobe(input bit fs, input bit d);
        @(negedge clk);
        line_stb = 1'b1; frame_s = fs; dir = d;
        @(negedge clk);
        line_stb = 1'b0; frame_s = 1'b0;
    endtask

    initial begin
        //            fs d  g  b gap row dn re f0 f2
        // Frame 1: forward scan, 5 strobes.
        vecs[0]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 1, 1);
        vecs[1]  = mk(0, 0, 1, 0, 1, 1, 0, 0, 1, 1);
        vecs[2]  = mk(0, 0, 1, 0, 0, 2, 0, 0, 1, 0);
        vecs[3]  = mk(0, 0, 1, 0, 0, 3, 0, 0, 1, 0);
        vecs[4]  = mk(0, 0, 1, 0, 1, 4, 1, 0, 1, 1);
        // Frame 2: reverse scan, dir wiggled mid-frame.
        vecs[5]  = mk(1, 1, 1, 0, 0, 3, 0, 0, 0, 0);
        vecs[6]  = mk(0, 0, 1, 0, 0, 2, 0, 0, 0, 0);
        vecs[7]  = mk(0, 1, 1, 0, 1, 1, 0, 0, 0, 1);
        vecs[8]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        vecs[9]  = mk(0, 0, 1, 0, 2, 4, 1, 0, 0, 0);
        // Frame 3: gate low / blank high while the token keeps moving.
        vecs[10] = mk(1, 0, 1, 0, 0, 0, 0, 0, 1, 1);
        vecs[11] = mk(0, 0, 0, 0, 1, 1, 0, 0, 1, 1);
        vecs[12] = mk(0, 0, 1, 1, 0, 2, 0, 0, 1, 0);
        vecs[13] = mk(0, 0, 1, 0, 0, 3, 0, 0, 1, 0);
        // Frame start on the last-lane step: done and restart together.
        vecs[14] = mk(1, 0, 1, 0, 1, 0, 1, 1, 0, 1);
        vecs[15] = mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 1);
        vecs[16] = mk(0, 0, 1, 0, 0, 2, 0, 0, 0, 0);
        // Frame start at row 2: restart only.
        vecs[17] = mk(1, 0, 1, 0, 0, 0, 0, 1, 1, 1);
        vecs[18] = mk(0, 0, 1, 0, 0, 1, 0, 0, 1, 1);
        vecs[19] = mk(0, 0, 1, 0, 0, 2, 0, 0, 1, 0);
        vecs[20] = mk(0, 0, 1, 0, 0, 3, 0, 0, 1, 0);
        vecs[21] = mk(0, 0, 1, 0, 2, 4, 1, 0, 1, 1);

        // Reset values, visible as soon as rst_n falls.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_row_idx", int'(row_a), LANES);
        chk("rst_lane_out", int'(lane_a), 4'hF);
        chk("rst_fr", int'(fr_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_pulses", int'({done_a, rerr_a}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        cur.row = LANES; cur.done = 1'b0; cur.rerr = 1'b0; cur.fr0 = 1'b0; cur.fr2 = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
        for (int i = 0; i < 22; i++) drive_vec(vecs[i]);
        @(negedge clk);
        line_stb = 1'b0; frame_s = 1'b0; gate = 1'b1; blank = 1'b0;
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        chk("scoreboard_drained", sb.size(), 0);

        // Asynchronous reset mid-frame at row 2. Both FR values are 1 here.
        strobe(1'b1, 1'b0);   // row 0, fr_a 0
        strobe(1'b0, 1'b0);   // row 1
        strobe(1'b0, 1'b0);   // row 2
        chk("pre_rst_row", int'(row_a), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_row", int'(row_a), LANES);
        chk("async_rst_lane", int'(lane_a), 4'hF);
        chk("async_rst_fr_a", int'(fr_a), 0);
        chk("async_rst_fr_b", int'(fr_b), 0);
        chk("async_rst_busy", int'(busy_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        // Stays idle on plain strobes; line inversion keeps running.
        strobe(1'b0, 1'b0);
        strobe(1'b0, 1'b0);
        chk("idle_row", int'(row_a), LANES);
        chk("idle_busy", int'(busy_a), 0);
        chk("idle_fr_a", int'(fr_a), 0);
        chk("idle_fr_b", int'(fr_b), 1);
        strobe(1'b1, 1'b1);
        chk("post_rst_start_row", int'(row_a), 3);
        chk("post_rst_busy", int'(busy_a), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
